// File: rtl/seven_segment_scan.sv
// Time-multiplexed seven-segment driver; optional leading-zero blanking under SEG_ZERO_BLANK_EN.
// Latency: outputs registered from post-edge state; a loaded value appears on digit 0 of the next frame.
// Backpressure: none, load is always accepted and the last load before a frame wrap wins.
module seven_segment_scan #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int CNT_W    = $clog2(SCAN_DIV),
    parameter int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [4*DIGITS-1:0] shadow, shadow_nxt;
    logic [4*DIGITS-1:0] pending, pending_nxt;
    logic                pend_v, pend_v_nxt;
    logic                term, wrap;
    logic [3:0]          nib;
    logic                blank;
    logic [6:0]          seg_nxt;
    logic [DIGITS-1:0]   an_nxt;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'b1111110;
            4'h1: decode = 7'b0110000;
            4'h2: decode = 7'b1101101;
            4'h3: decode = 7'b1111001;
            4'h4: decode = 7'b0110011;
            4'h5: decode = 7'b1011011;
            4'h6: decode = 7'b1011111;
            4'h7: decode = 7'b1110000;
            4'h8: decode = 7'b1111111;
            4'h9: decode = 7'b1111011;
            4'hA: decode = 7'b1110111;
            4'hB: decode = 7'b0011111;
            4'hC: decode = 7'b1001110;
            4'hD: decode = 7'b0111101;
            4'hE: decode = 7'b1001111;
            default: decode = 7'b1000111;
        endcase
    endfunction

    always_comb begin
        term        = (cnt == CNT_LAST);
        wrap        = term && (idx == IDX_LAST);
        cnt_nxt     = term ? '0 : cnt + CNT_W'(1);
        idx_nxt     = idx;
        if (term) begin
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end
        shadow_nxt  = shadow;
        pending_nxt = pending;
        pend_v_nxt  = pend_v;
        // A load coinciding with the wrap is newer than anything pending, so it goes straight to shadow.
        if (wrap) begin
            pend_v_nxt = 1'b0;
            if (load) begin
                shadow_nxt = value;
            end else if (pend_v) begin
                shadow_nxt = pending;
            end
        end else if (load) begin
            pending_nxt = value;
            pend_v_nxt  = 1'b1;
        end
    end

    always_comb begin
        nib    = 4'h0;
        blank  = 1'b0;
        an_nxt = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_nxt == IDX_W'(k)) begin
                nib       = shadow_nxt[4*k +: 4];
                an_nxt[k] = 1'b1;
`ifdef SEG_ZERO_BLANK_EN
                blank     = (k > 0) && ((shadow_nxt >> (4*k)) == '0);
`endif
            end
        end
        seg_nxt = blank ? 7'b0 : decode(nib);
        // First cycle of every slot is dark so the previous digit cannot ghost onto the next enable.
        if (cnt_nxt == '0) begin
            an_nxt  = '0;
            seg_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= '0;
            shadow  <= '0;
            pending <= '0;
            pend_v  <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            shadow  <= shadow_nxt;
            pending <= pending_nxt;
            pend_v  <= pend_v_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= '0;
            an         <= '0;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_nxt;
            an         <= an_nxt;
            frame_done <= wrap;
        end
    end
endmodule

// File: tb/tb_seven_segment_scan.sv
// Bench for seven_segment_scan with DIGITS=4, SCAN_DIV=4; expected scan outputs are queued per edge.
module tb_seven_segment_scan;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int FRAME    = DIGITS * SCAN_DIV;

`ifdef SEG_ZERO_BLANK_EN
    localparam logic [6:0] BLK = 7'b0000000;
`else
    localparam logic [6:0] BLK = 7'b1111110;
`endif
    localparam logic [27:0] ZEROS = {BLK, BLK, BLK, 7'b1111110};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    seven_segment_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .seg(seg), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
    } obs_t;

    typedef struct {
        logic [15:0] value;
        logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    obs_t        sb_q[$];
    vec_t        vecs[6];
    int          total = 0;
    int          bad = 0;
    int          edge_n = 0;
    logic [27:0] disp = ZEROS;
    logic [27:0] next_disp = ZEROS;
    logic        has_next = 1'b0;

    task automatic check(input string name, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d: got an=%b seg=%b fd=%b, expected an=%b seg=%b fd=%b",
                     name, edge_n, act.an, act.seg, act.fd, exp.an, exp.seg, exp.fd);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.an  = an;
        o.seg = seg;
        o.fd  = frame_done;
        return o;
    endfunction

    task automatic tick();
        obs_t e;
        int   c;
        int   d;
        edge_n++;
        c = edge_n % SCAN_DIV;
        d = (edge_n / SCAN_DIV) % DIGITS;
        if ((edge_n % FRAME == 0) && has_next) begin
            disp     = next_disp;
            has_next = 1'b0;
        end
        e.an  = (c == 0) ? 4'b0000 : 4'(1 << d);
        e.seg = (c == 0) ? 7'b0 : disp[7*d +: 7];
        e.fd  = (edge_n % FRAME == 0);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check("scan", sample(), sb_q.pop_front());
    endtask

    task automatic do_load(input logic [15:0] v, input logic [27:0] segs);
        value     = v;
        load      = 1'b1;
        next_disp = segs;
        has_next  = 1'b1;
        tick();
        load      = 1'b0;
    endtask

    task automatic run_to_wrap();
        while (edge_n % FRAME != 0) tick();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        vecs[0] = '{16'h1234, {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}};
        vecs[1] = '{16'h6789, {7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011}};
        vecs[2] = '{16'hCDA0, {7'b1001110, 7'b0111101, 7'b1110111, 7'b1111110}};
        vecs[3] = '{16'h0050, {BLK, BLK, 7'b1011011, 7'b1111110}};
        vecs[4] = '{16'h0800, {BLK, 7'b1111111, 7'b1111110, 7'b1111110}};
        vecs[5] = '{16'h0000, ZEROS};

        // Power-on reset: outputs dark before and across a clock edge.
        #2 rst_n = 1'b0;
        #1 check("reset_async", sample(), '0);
        #4 check("reset_held", sample(), '0);
        #1 rst_n = 1'b1;   // t=8, next posedge at t=15 is edge 1

        // Idle scan of zeros for two frames, including both frame_done pulses.
        run(2 * FRAME);

        // Each vector loaded mid-frame, shown from the following frame only.
        for (int v = 0; v < 6; v++) begin
            run(5);
            do_load(vecs[v].value, vecs[v].segs);
            run_to_wrap();
            run(FRAME);
        end

        // Two loads in one frame: only the later one is ever displayed.
        run(3);
        do_load(16'hAAAA, {4{7'b1110111}});
        run(4);
        do_load(16'hBEEF, {7'b0011111, 7'b1001111, 7'b1001111, 7'b1000111});
        run_to_wrap();
        run(FRAME);

        // Load on the wrap edge itself while older data is pending; two frames confirm pending was dropped.
        run(4);
        do_load(16'hAAAA, {4{7'b1110111}});
        while (edge_n % FRAME != FRAME - 1) tick();
        do_load(16'h6789, vecs[1].segs);
        run(2 * FRAME);

        // Asynchronous reset in the middle of a digit slot, with a pending load outstanding.
        run(2);
        do_load(16'h1234, vecs[0].segs);
        run(3);
        #3 rst_n = 1'b0;
        #1 check("reset_mid", sample(), '0);
        #6 rst_n = 1'b1;
        edge_n    = 0;
        disp      = ZEROS;
        has_next  = 1'b0;
        sb_q.delete();
        run(FRAME + 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
